// File: rtl/windowed_framer.sv
// windowed_framer
// Keeps the most recent N_POINTS signed samples in a circular buffer. Every HOP
// new samples it launches a frame, so windows can overlap. Each point k is
// multiplied by a programmable unsigned coefficient coef[k]. The product is
// floored by 2^COEF_FRAC and saturated to OUT_W bits. Points are streamed out
// one per cycle under a valid/ready handshake.
//
// Ports:
//   clk, rst                    sole clock, synchronous active-high reset
//   sample_valid, sample_in     one-cycle sample strobe and signed sample
//   coef_we/addr/data           coefficient table write (honoured only when idle)
//   frame_valid/ready           output handshake
//   frame_data                  windowed point, signed OUT_W
//   frame_index, frame_last     point index k, high on k = N_POINTS-1
//   busy                        a frame is being streamed
//   overrun                     sticky: an unread slot of the live frame was overwritten
//   drop_count                  saturating count of frame launches that were lost
module windowed_framer #(
  parameter int N_POINTS  = 16,
  parameter int HOP       = 16,
  parameter int SAMPLE_W  = 12,
  parameter int COEF_W    = 8,
  parameter int COEF_FRAC = 7,
  parameter int OUT_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_valid,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        coef_we,
  input  logic [$clog2(N_POINTS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]           coef_data,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [OUT_W-1:0]            frame_data,
  output logic [$clog2(N_POINTS)-1:0] frame_index,
  output logic                        frame_last,
  output logic                        busy,
  output logic                        overrun,
  output logic [15:0]                 drop_count
);
  localparam int AW = $clog2(N_POINTS);
  localparam int PW = SAMPLE_W + COEF_W + 1;
  localparam int CW = (PW > OUT_W) ? PW : OUT_W;
  localparam logic [AW:0]         HOP_CNT    = (AW+1)'(HOP);
  localparam logic [AW-1:0]       LAST_K     = AW'(N_POINTS - 1);
  localparam logic [COEF_W-1:0]   COEF_UNITY = COEF_W'(1) << COEF_FRAC;
  localparam logic signed [CW-1:0] OUT_MAX   = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] OUT_MIN   = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW:0]         new_cnt_q, new_cnt_d;
  logic                primed_q, primed_d;
  logic                pending_q, pending_d;
  logic [AW-1:0]       start_q, start_d;
  logic [AW:0]         rd_k_q, rd_k_d;
  logic [AW:0]         acc_q, acc_d;
  logic                s1_valid_q, s1_valid_d;
  logic [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;
  logic [COEF_W-1:0]   s1_coef_q, s1_coef_d;
  logic [AW-1:0]       s1_k_q, s1_k_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [AW-1:0]       out_k_q, out_k_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         drop_q, drop_d;

  logic [SAMPLE_W-1:0] smp_mem_q [N_POINTS];
  logic [COEF_W-1:0]   coef_q [N_POINTS];

  logic                hop, accept, last_accept, launch;
  logic                out_free, s1_free, issue, coef_wr;
  logic [AW-1:0]       rd_addr, slot_k;
  logic [AW:0]         acc_eff;
  logic signed [PW-1:0] s_ext, c_ext, prod, shifted;
  logic signed [CW-1:0] wide;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    new_cnt_d   = new_cnt_q;
    primed_d    = primed_q;
    pending_d   = pending_q;
    start_d     = start_q;
    rd_k_d      = rd_k_q;
    acc_d       = acc_q;
    s1_valid_d  = s1_valid_q;
    s1_sample_d = s1_sample_q;
    s1_coef_d   = s1_coef_q;
    s1_k_d      = s1_k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;
    overrun_d   = overrun_q;
    drop_d      = drop_q;

    hop         = primed_q && (new_cnt_q == HOP_CNT);
    accept      = out_valid_q && frame_ready;
    last_accept = accept && (out_k_q == LAST_K);
    // A pending launch left over from the previous frame is served from IDLE
    launch      = (state_q == IDLE) && (hop || pending_q);
    out_free    = !out_valid_q || frame_ready;
    s1_free     = !s1_valid_q || out_free;
    issue       = (state_q == STREAM) && !rd_k_q[AW] && s1_free;
    coef_wr     = coef_we && (state_q == IDLE);
    rd_addr     = start_q + rd_k_q[AW-1:0];
    slot_k      = wptr_q - start_q;
    acc_eff     = acc_q + {{AW{1'b0}}, accept};

    if (sample_valid) begin
      wptr_d = wptr_q + 1'b1;
      if (wptr_q == LAST_K) primed_d = 1'b1;
    end

    // Before priming the counter parks at HOP; once primed, reaching HOP is a hop event
    if (hop) new_cnt_d = {{AW{1'b0}}, sample_valid};
    else if (sample_valid && (new_cnt_q != HOP_CNT)) new_cnt_d = new_cnt_q + 1'b1;

    // A write on the launch edge lands in the oldest slot of the new window,
    // which has not been read yet, so it is reported like any other overwrite
    if (sample_valid && (launch || ((state_q == STREAM) && ({1'b0, slot_k} >= acc_eff))))
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = STREAM;
          start_d   = wptr_q;
          rd_k_d    = '0;
          acc_d     = '0;
          pending_d = pending_q && hop;
        end
      end
      STREAM: begin
        if (hop) begin
          if (pending_q) drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          else pending_d = 1'b1;
        end
        if (issue) rd_k_d = rd_k_q + 1'b1;
        if (accept) acc_d = acc_q + 1'b1;
        if (last_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stage 1: buffer and coefficient read
    if (s1_free) begin
      s1_valid_d = issue;
      if (issue) begin
        s1_sample_d = smp_mem_q[rd_addr];
        s1_coef_d   = coef_q[rd_k_q[AW-1:0]];
        s1_k_d      = rd_k_q[AW-1:0];
      end
    end

    // Stage 2: multiply, floor shift, saturate
    s_ext   = PW'(signed'(s1_sample_q));
    c_ext   = {{(PW-COEF_W){1'b0}}, s1_coef_q};
    prod    = s_ext * c_ext;
    shifted = prod >>> COEF_FRAC;
    wide    = CW'(shifted);
    if (out_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_k_d = s1_k_q;
        if (wide > OUT_MAX) out_data_d = OUT_W'(OUT_MAX);
        else if (wide < OUT_MIN) out_data_d = OUT_W'(OUT_MIN);
        else out_data_d = OUT_W'(wide);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      new_cnt_q   <= '0;
      primed_q    <= 1'b0;
      pending_q   <= 1'b0;
      start_q     <= '0;
      rd_k_q      <= '0;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_coef_q   <= '0;
      s1_k_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
      for (int i = 0; i < N_POINTS; i++) coef_q[i] <= COEF_UNITY;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      new_cnt_q   <= new_cnt_d;
      primed_q    <= primed_d;
      pending_q   <= pending_d;
      start_q     <= start_d;
      rd_k_q      <= rd_k_d;
      acc_q       <= acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_coef_q   <= s1_coef_d;
      s1_k_q      <= s1_k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
      if (coef_wr) coef_q[coef_addr] <= coef_data;
    end
  end

  // Sample storage needs no reset: priming guarantees every slot is rewritten before use
  always_ff @(posedge clk) begin
    if (sample_valid) smp_mem_q[wptr_q] <= sample_in;
  end

  assign frame_valid = out_valid_q;
  assign frame_data  = out_data_q;
  assign frame_index = out_k_q;
  assign frame_last  = out_valid_q && (out_k_q == LAST_K);
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign drop_count  = drop_q;
endmodule

// File: tb/tb_windowed_framer.sv
module tb_windowed_framer;
  localparam int N = 16;

  logic        clk;
  logic        rst, sample_valid, coef_we, tb_ready, sel;
  logic [11:0] sample_in;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;

  logic        a_valid, a_ready, a_last, a_busy, a_ovr;
  logic [11:0] a_data;
  logic [3:0]  a_index;
  logic [15:0] a_drops;
  logic        b_valid, b_ready, b_last, b_busy, b_ovr;
  logic [11:0] b_data;
  logic [3:0]  b_index;
  logic [15:0] b_drops;

  logic        fv, fl, bz, ovr;
  logic [11:0] fd;
  logic [3:0]  fi;
  logic [15:0] dc;

  int n_checks = 0;
  int n_fail   = 0;
  int hist[$];
  int coef_m[N];
  int exp_q[N];
  bit exp_mask[N];

  // Two instances share stimulus; sel picks which one is observed and handshaken
  windowed_framer #(.N_POINTS(16), .HOP(16)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .frame_valid(a_valid), .frame_ready(a_ready), .frame_data(a_data),
    .frame_index(a_index), .frame_last(a_last), .busy(a_busy),
    .overrun(a_ovr), .drop_count(a_drops));

  windowed_framer #(.N_POINTS(16), .HOP(4)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .frame_valid(b_valid), .frame_ready(b_ready), .frame_data(b_data),
    .frame_index(b_index), .frame_last(b_last), .busy(b_busy),
    .overrun(b_ovr), .drop_count(b_drops));

  assign a_ready = sel ? 1'b1 : tb_ready;
  assign b_ready = sel ? tb_ready : 1'b1;
  assign fv  = sel ? b_valid : a_valid;
  assign fl  = sel ? b_last  : a_last;
  assign fd  = sel ? b_data  : a_data;
  assign fi  = sel ? b_index : a_index;
  assign bz  = sel ? b_busy  : a_busy;
  assign ovr = sel ? b_ovr   : a_ovr;
  assign dc  = sel ? b_drops : a_drops;

  always #5 clk = ~clk;

  // Reference point: floor(sample*coef / 128) saturated to 12-bit signed
  function automatic int model_point(int s, int c);
    int p, q;
    p = s * c;
    q = p / 128;
    if (((p % 128) != 0) && (p < 0)) q = q - 1;
    if (q > 2047) q = 2047;
    else if (q < -2048) q = -2048;
    return q;
  endfunction

  // Expected frame = the 16 most recent samples written, weighted by the coefficient table
  function automatic void build_expected();
    for (int k = 0; k < N; k++) begin
      exp_q[k]    = model_point(hist[hist.size() - N + k], coef_m[k]);
      exp_mask[k] = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int v);
    sample_in    = v[11:0];
    sample_valid = 1'b1;
    hist.push_back(v);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic applyCoef(input int addr, input int val, input bit accepted);
    coef_addr = addr[3:0];
    coef_data = val[7:0];
    coef_we   = 1'b1;
    @(negedge clk);
    coef_we = 1'b0;
    if (accepted) coef_m[addr] = val;
  endtask

  task automatic doReset();
    rst = 1'b1;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    for (int k = 0; k < N; k++) coef_m[k] = 128;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int c = 0;
    while (!fv && (c < limit)) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_valid_seen"}, 32'(fv), 1);
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
  task automatic collect_frame(input string tag, input int mode);
    int beats = 0;
    int cyc = 0;
    while ((beats < N) && (cyc < 300)) begin
      tb_ready = (mode == 0) || ((cyc % 3) == 0);
      if (fv) begin
        checkOutput({tag, "_index"}, 32'(fi), beats);
        if (exp_mask[beats]) checkOutput({tag, "_data"}, $signed(fd), exp_q[beats]);
        checkOutput({tag, "_last"}, 32'(fl), 32'(beats == N - 1));
        if (tb_ready) beats++;
      end else if (beats > 0) begin
        checkOutput({tag, "_valid_gap"}, 32'(fv), 1);
      end
      @(negedge clk);
      cyc++;
    end
    tb_ready = 1'b1;
    if (beats < N) checkOutput({tag, "_timeout"}, beats, N);
  endtask

  initial begin
    int v, cnt;
    clk = 1'b0;
    sel = 1'b0;
    tb_ready = 1'b1;
    sample_in = '0;
    coef_addr = '0;
    coef_data = '0;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(fv), 0);
    checkOutput("rst_data", 32'(fd), 0);
    checkOutput("rst_index", 32'(fi), 0);
    checkOutput("rst_last", 32'(fl), 0);
    checkOutput("rst_busy", 32'(bz), 0);
    checkOutput("rst_overrun", 32'(ovr), 0);
    checkOutput("rst_drops", 32'(dc), 0);

    $display("[TB] unity window, HOP=16, launch latency");
    for (int i = 0; i < N; i++) applyStimulus(i);
    build_expected();
    checkOutput("lat_e0", 32'(fv), 0);
    @(negedge clk);
    checkOutput("lat_e1", 32'(fv), 0);
    checkOutput("lat_busy", 32'(bz), 1);
    @(negedge clk);
    checkOutput("lat_e2", 32'(fv), 0);
    @(negedge clk);
    checkOutput("lat_e3", 32'(fv), 1);
    collect_frame("unity", 0);
    checkOutput("unity_after_last", 32'(fv), 0);
    checkOutput("unity_idle", 32'(bz), 0);
    checkOutput("unity_drops", 32'(dc), 0);

    $display("[TB] windowing and rounding");
    applyCoef(3, 64, 1'b1);
    applyCoef(5, 255, 1'b1);
    for (int i = 0; i < N; i++) applyStimulus((i == 5) ? 2047 : -3);
    build_expected();
    wait_valid("win", 10);
    collect_frame("win", 0);

    $display("[TB] random coefficients with backpressure");
    for (int k = 0; k < N; k++) applyCoef(k, int'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < N; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    build_expected();
    wait_valid("bp", 10);
    collect_frame("bp", 1);
    repeat (3) @(negedge clk);
    checkOutput("bp_no_extra", 32'(fv), 0);
    checkOutput("bp_overrun", 32'(ovr), 0);

    $display("[TB] coefficient write while busy is ignored");
    for (int i = 0; i < N; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    build_expected();
    @(negedge clk);
    checkOutput("cw_busy", 32'(bz), 1);
    applyCoef(0, 0, 1'b0);
    wait_valid("cw", 10);
    collect_frame("cw", 0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < N; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    wait_valid("mr", 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    for (int k = 0; k < N; k++) coef_m[k] = 128;
    checkOutput("mr_valid", 32'(fv), 0);
    checkOutput("mr_data", 32'(fd), 0);
    checkOutput("mr_index", 32'(fi), 0);
    checkOutput("mr_last", 32'(fl), 0);
    checkOutput("mr_busy", 32'(bz), 0);
    checkOutput("mr_overrun", 32'(ovr), 0);
    checkOutput("mr_drops", 32'(dc), 0);
    for (int i = 0; i < N - 1; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    repeat (8) @(negedge clk);
    checkOutput("mr_unprimed_valid", 32'(fv), 0);
    checkOutput("mr_unprimed_busy", 32'(bz), 0);
    applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    build_expected();
    wait_valid("mr", 10);
    collect_frame("mr", 0);

    $display("[TB] overlapping frames, HOP=4");
    sel = 1'b1;
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i);
    build_expected();
    wait_valid("ov0", 10);
    collect_frame("ov0", 0);
    for (int i = N; i < N + 4; i++) applyStimulus(i);
    build_expected();
    wait_valid("ov1", 10);
    collect_frame("ov1", 0);
    for (int h = 0; h < 3; h++) begin
      applyCoef(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
      build_expected();
      wait_valid("ovr", 10);
      collect_frame("ovr", (h == 1) ? 1 : 0);
    end
    checkOutput("ov_overrun", 32'(ovr), 0);

    $display("[TB] pending launch and dropped frame");
    tb_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    build_expected();
    for (int k = 0; k < 8; k++) exp_mask[k] = 1'b0;
    wait_valid("pd", 10);
    for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    @(negedge clk);
    checkOutput("pd_no_drop_yet", 32'(dc), 0);
    for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(0, 4095)) - 2048);
    @(negedge clk);
    checkOutput("pd_drops", 32'(dc), 1);
    checkOutput("pd_overrun", 32'(ovr), 1);
    checkOutput("pd_stalled_valid", 32'(fv), 1);
    collect_frame("pd_cur", 0);
    checkOutput("pd_gap_valid", 32'(fv), 0);
    checkOutput("pd_gap_idle", 32'(bz), 0);
    build_expected();
    @(negedge clk);
    checkOutput("pd_relaunch_busy", 32'(bz), 1);
    checkOutput("pd_relaunch_valid1", 32'(fv), 0);
    @(negedge clk);
    checkOutput("pd_relaunch_valid2", 32'(fv), 0);
    @(negedge clk);
    checkOutput("pd_relaunch_valid3", 32'(fv), 1);
    collect_frame("pd_next", 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (fv) cnt++;
      @(negedge clk);
    end
    checkOutput("pd_single_followup", cnt, 0);
    checkOutput("pd_drops_final", 32'(dc), 1);
    v = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
